// File: rtl/mul_pkg.sv
// mul_pkg: shared state type and default sizing for the multiplier driver.
package mul_pkg;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, HOLD} mul_driver_state_t;
   localparam int MUL_WIDTH = 10;
   localparam int MUL_TIMEOUT = 16;
endpackage

// File: rtl/mul_driver_if.sv
// mul_driver_if: operand stream, multiplier start/valid bus and result stream of the driver.
interface mul_driver_if import mul_pkg::*; #(parameter int WIDTH = MUL_WIDTH);
   logic in_valid, in_ready;
   logic signed [WIDTH:0] in_a, in_b;
   logic mul_start, mul_valid;
   logic signed [WIDTH:0] mul_a, mul_b;
   logic signed [2*WIDTH+1:0] mul_c;
   logic out_valid, out_ready, out_err;
   logic signed [2*WIDTH+1:0] out_c;
   modport master (
      input in_valid, in_a, in_b, mul_c, mul_valid, out_ready,
      output in_ready, mul_start, mul_a, mul_b, out_valid, out_c, out_err
   );
   modport slave (
      output in_valid, in_a, in_b, mul_c, mul_valid, out_ready,
      input in_ready, mul_start, mul_a, mul_b, out_valid, out_c, out_err
   );
endinterface

// File: rtl/cycle_watchdog.sv
// cycle_watchdog: counts enabled cycles since the last clear; expired while the count equals limit.
module cycle_watchdog #(parameter int CW = 5) (
   input logic clock,
   input logic reset,
   input logic clear,
   input logic enable,
   input logic [CW-1:0] limit,
   output logic expired
);
   logic [CW-1:0] count;
   always_ff @(posedge clock)
      if (reset || clear) count <= '0;
      else if (enable && !expired) count <= count + 1'b1;
   assign expired = count == limit;
endmodule

// File: rtl/mul_driver.sv
// mul_driver: accepts operand pairs, pulses start to a multi-cycle multiplier and buffers its product.
// Defining MUL_DRIVER_TIMEOUT_EN adds a WAIT watchdog that returns a zero product flagged by out_err.
module mul_driver import mul_pkg::*; #(
   parameter int WIDTH = MUL_WIDTH,
   parameter int TIMEOUT = MUL_TIMEOUT
) (
   input logic clock,
   input logic reset,
   mul_driver_if.master bus
);
   mul_driver_state_t state, next;
   logic timeout;
   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("TIMEOUT must be at least 2");
   end
`ifdef MUL_DRIVER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic expired;
   cycle_watchdog #(.CW(CW)) u_watchdog (
      .clock(clock),
      .reset(reset),
      .clear(state == ISSUE),
      .enable(state == WAIT && !bus.mul_valid),
      .limit(CW'(TIMEOUT - 1)),
      .expired(expired)
   );
   // a late mul_valid on the expiry cycle still wins over the timeout
   assign timeout = state == WAIT && !bus.mul_valid && expired;
`else
   assign timeout = 1'b0;
`endif
   always_ff @(posedge clock)
      if (reset) begin
         state <= IDLE;
         bus.mul_a <= '0;
         bus.mul_b <= '0;
         bus.out_c <= '0;
         bus.out_err <= 1'b0;
      end else begin
         state <= next;
         if (state == IDLE && bus.in_valid) begin
            bus.mul_a <= bus.in_a;
            bus.mul_b <= bus.in_b;
         end
         if (state == CAPTURE) begin
            bus.out_c <= bus.mul_c;
            bus.out_err <= 1'b0;
         end else if (timeout) begin
            bus.out_c <= '0;
            bus.out_err <= 1'b1;
         end
      end
   // mul_c is registered in the multiplier, so it is sampled in CAPTURE, one cycle after mul_valid
   always_comb begin
      next = state;
      case (state)
         IDLE: next = bus.in_valid ? ISSUE : IDLE;
         ISSUE: next = WAIT;
         WAIT: next = bus.mul_valid ? CAPTURE : timeout ? HOLD : WAIT;
         CAPTURE: next = HOLD;
         HOLD: next = bus.out_ready ? IDLE : HOLD;
         default: next = IDLE;
      endcase
   end
   assign bus.in_ready = state == IDLE;
   assign bus.mul_start = state == ISSUE;
   assign bus.out_valid = state == HOLD;
endmodule

// File: tb/tb_mul_driver.sv
// tb_mul_driver: directed and random transactions against a multiplier model and a transaction scoreboard.
module tb_mul_driver;
   localparam int W = 10;
   localparam int IW = W + 1;
   localparam int PW = 2 * W + 2;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int failures = 0;
   bit mon_en = 1'b0;
   bit stub = 1'b0;
   int mlat = 1;
   mul_driver_if #(.WIDTH(W)) bus ();
   mul_driver #(.WIDTH(W), .TIMEOUT(16)) dut (.clock(clock), .reset(reset), .bus(bus.master));
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // multiplier: valid mlat cycles after start, product registered one cycle after valid; stub never answers
   longint pa, pb;
   bit pend;
   int cnt;
   always @(posedge clock)
      if (reset) begin
         pend <= 1'b0;
         cnt <= 0;
         bus.mul_valid <= 1'b0;
      end else begin
         bus.mul_valid <= 1'b0;
         if (bus.mul_valid) bus.mul_c <= PW'(pa * pb);
         if (bus.mul_start && !stub) begin
            pa <= longint'(bus.mul_a);
            pb <= longint'(bus.mul_b);
            if (mlat <= 1) bus.mul_valid <= 1'b1;
            else begin
               pend <= 1'b1;
               cnt <= mlat - 1;
            end
         end else if (pend) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
               bus.mul_valid <= 1'b1;
               pend <= 1'b0;
            end
         end
      end

   // scoreboard: one transaction in flight at most; every accept yields exactly one result
   typedef struct {longint c; bit err;} exp_t;
   exp_t q[$];
   bit busy = 1'b0;
   bit start_exp = 1'b0;
   logic signed [IW-1:0] ea = '0, eb = '0;
   always @(negedge clock)
      if (mon_en) begin
         chk("in_ready", bus.in_ready, !busy);
         chk("mul_start", bus.mul_start, start_exp);
         chk("mul_a", bus.mul_a, ea);
         chk("mul_b", bus.mul_b, eb);
         if (bus.out_valid) begin
            if (q.size() == 0) chk("out_valid_idle", bus.out_valid, 0);
            else begin
               chk("out_c", bus.out_c, q[0].c);
               chk("out_err", bus.out_err, q[0].err);
            end
         end
         start_exp = 1'b0;
         if (reset) begin
            busy = 1'b0;
            q.delete();
            ea = '0;
            eb = '0;
         end else begin
            if (bus.out_valid && bus.out_ready) begin
               if (q.size() > 0) void'(q.pop_front());
               busy = 1'b0;
            end else if (!busy && bus.in_valid) begin
               busy = 1'b1;
               start_exp = 1'b1;
               ea = bus.in_a;
               eb = bus.in_b;
               q.push_back('{c: stub ? 0 : longint'(bus.in_a) * longint'(bus.in_b), err: stub});
            end
         end
      end

   task automatic txn(input int a, input int b, input int hold, input longint exp, input bit exp_err,
                      input int exp_lat, input string nm);
      int n, k, starts;
      bus.in_a = IW'(a);
      bus.in_b = IW'(b);
      bus.in_valid = 1'b1;
      bus.out_ready = hold == 0;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         tick();
         n++;
      end
      if (n == 50) chk({nm, "_accept_timeout"}, n, 0);
      tick();
      bus.in_valid = hold > 0;
      bus.in_a = IW'(a + 1);
      k = 1;
      starts = 0;
      while (!bus.out_valid && k < 40) begin
         starts += int'(bus.mul_start);
         tick();
         k++;
      end
      chk({nm, "_start_count"}, starts, 1);
      if (exp_lat > 0) chk({nm, "_latency"}, k, exp_lat);
      chk({nm, "_c"}, bus.out_c, exp);
      chk({nm, "_err"}, bus.out_err, exp_err);
      for (int i = 0; i < hold; i++) begin
         chk({nm, "_bp_valid"}, bus.out_valid, 1);
         chk({nm, "_bp_c"}, bus.out_c, exp);
         chk({nm, "_bp_in_ready"}, bus.in_ready, 0);
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk({nm, "_xfer"}, bus.out_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=1 required=0");
      $fatal(1);
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_a = '0;
      bus.in_b = '0;
      bus.out_ready = 1'b0;
      bus.mul_c = '0;
      tick();
      tick();
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_mul_start", bus.mul_start, 0);
      chk("rst_mul_a", bus.mul_a, 0);
      chk("rst_mul_b", bus.mul_b, 0);
      chk("rst_out_c", bus.out_c, 0);
      chk("rst_out_err", bus.out_err, 0);
      reset = 1'b0;
      mon_en = 1'b1;
      txn(-3, 7, 0, -21, 0, 4, "basic");
      txn(1023, -1024, 0, -1047552, 0, 4, "ext_mix");
      txn(-1024, -1024, 0, 1048576, 0, 4, "ext_neg");
      txn(5, 6, 5, 30, 0, 4, "backpressure");
      txn(2, 3, 0, 6, 0, 4, "b2b_0");
      txn(-4, 5, 0, -20, 0, 4, "b2b_1");
      txn(0, -9, 0, 0, 0, 4, "b2b_2");
`ifdef MUL_DRIVER_TIMEOUT_EN
      stub = 1'b1;
      txn(1, 1, 0, 0, 1, 18, "timeout");
      stub = 1'b0;
      txn(3, -2, 0, -6, 0, 4, "after_timeout");
`endif
      mlat = 4;
      bus.in_a = IW'(9);
      bus.in_b = IW'(9);
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midwait_in_ready", bus.in_ready, 1);
      chk("midwait_out_valid", bus.out_valid, 0);
      chk("midwait_mul_a", bus.mul_a, 0);
      chk("midwait_mul_b", bus.mul_b, 0);
      mlat = 1;
      txn(2, 2, 0, 4, 0, 4, "after_reset");
      for (int i = 0; i < 600; i++) begin
         bus.in_valid = ($urandom % 3) != 0;
         bus.in_a = ($urandom % 5 == 0) ? (($urandom % 2) ? IW'(1023) : IW'(-1024)) : IW'($urandom);
         bus.in_b = ($urandom % 5 == 0) ? (($urandom % 2) ? IW'(1023) : IW'(-1024)) : IW'($urandom);
         bus.out_ready = ($urandom % 2) != 0;
         mlat = 1 + int'($urandom % 4);
         tick();
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      chk("drain_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
